mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: EX->WB memory-access stage; runs RISC-V loads/stores on a req/gnt/rvalid data port.
// Latency: pass-through 1 cycle; memory op 3 cycles with immediate gnt and rvalid, +1 per stalled cycle.
// Backpressure: result held in DONE while right_ready=0; left_ready stays low until the hand-off.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [212:0] ex_ctrl_bus,
    input  logic         left_valid,
    output logic         left_ready,
    output logic         right_valid,
    input  logic         right_ready,
    output logic [102:0] mem_ctrl_bus,
    output logic [37:0]  mem_bypass,
    output logic         load_pending,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [31:0]  dmem_addr,
    output logic [3:0]   dmem_wstrb,
    output logic [31:0]  dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [31:0]  dmem_rdata
);

    // Field positions inside the execute-stage bus.
    localparam int INST_VALID_BIT = 198;
    localparam int PC_LO          = 134;
    localparam int INST_LO        = 102;
    localparam int WREG_IDX_LO    = 97;
    localparam int WREG_EN_BIT    = 96;
    localparam int RS2_LO         = 64;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Decode of the instruction currently offered by the execute stage.
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_inst_valid;
    logic [31:0] in_addr;
    logic [1:0]  in_off;
    logic [31:0] in_rs2;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_mem;
    logic        accept;

    assign in_opcode     = ex_ctrl_bus[INST_LO +: 7];
    assign in_funct3     = ex_ctrl_bus[INST_LO + 12 +: 3];
    assign in_inst_valid = ex_ctrl_bus[INST_VALID_BIT];
    assign in_addr       = ex_ctrl_bus[31:0];
    assign in_off        = in_addr[1:0];
    assign in_rs2        = ex_ctrl_bus[RS2_LO +: 32];
    // Loads decode on opcode alone; a store only counts when the slot is a real instruction.
    assign in_is_load    = (in_opcode == OPC_LOAD);
    assign in_is_store   = (in_opcode == OPC_STORE) && in_inst_valid;
    assign in_is_mem     = in_is_load | in_is_store;

    assign left_ready = (state_q == IDLE) | ((state_q == DONE) & right_ready);
    assign accept     = left_valid & left_ready;

    // Held instruction and the registered memory request.
    logic [212:0] held_q;
    logic         is_load_q;
    logic         req_we_q;
    logic [31:0]  req_addr_q;
    logic [3:0]   req_wstrb_q;
    logic [31:0]  req_wdata_q;
    logic [31:0]  ld_data_q;

    logic [2:0]   held_funct3;
    logic [1:0]   held_off;
    logic [31:0]  held_result;

    assign held_funct3 = held_q[INST_LO + 12 +: 3];
    assign held_off    = held_q[1:0];
    assign held_result = held_q[31:0];

    // Store lane placement: strobes shifted by byte offset (overflow lanes fall off), data replicated.
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    // Build byte strobes and replicated store data from funct3 and the address offset.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = in_rs2;
        case (in_funct3)
            3'b000: begin
                st_wstrb = 4'b0001 << in_off;
                st_wdata = {4{in_rs2[7:0]}};
            end
            3'b001: begin
                st_wstrb = 4'b0011 << in_off;
                st_wdata = {2{in_rs2[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = in_rs2;
            end
        endcase
    end

    // Load data alignment and extension, based on the held instruction.
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    // Shift the returned word down to the addressed byte, then sign/zero-extend by funct3.
    always_comb begin
        ld_shift = dmem_rdata >> {held_off, 3'b000};
        ld_ext   = ld_shift;
        case (held_funct3)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept from IDLE/DONE, then gnt and rvalid advance a memory op to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_is_mem ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = in_is_mem ? ISSUE : DONE;
                end else if (right_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the whole instruction and precompute the request so it is stable through ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q      <= '0;
            is_load_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wstrb_q <= 4'h0;
            req_wdata_q <= 32'h0;
        end else if (accept) begin
            held_q      <= ex_ctrl_bus;
            is_load_q   <= in_is_load;
            req_we_q    <= in_is_store;
            req_addr_q  <= {in_addr[31:2], 2'b00};
            req_wstrb_q <= in_is_store ? st_wstrb : 4'h0;
            req_wdata_q <= in_is_store ? st_wdata : 32'h0;
        end
    end

    // Capture the extended load data as the response moves WAIT to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_data_q <= 32'h0;
        end else if ((state_q == WAIT) && dmem_rvalid) begin
            ld_data_q <= ld_ext;
        end
    end

    logic [31:0] wb_data;

    assign wb_data      = is_load_q ? ld_data_q : held_result;
    assign right_valid  = (state_q == DONE);
    assign load_pending = ((state_q == ISSUE) || (state_q == WAIT)) && is_load_q;

    assign dmem_req   = (state_q == ISSUE);
    assign dmem_we    = req_we_q;
    assign dmem_addr  = req_addr_q;
    assign dmem_wstrb = req_wstrb_q;
    assign dmem_wdata = req_wdata_q;

    assign mem_ctrl_bus = {held_q[INST_VALID_BIT],
                           held_q[PC_LO +: 32],
                           held_q[INST_LO +: 32],
                           held_q[WREG_IDX_LO +: 5],
                           held_q[WREG_EN_BIT],
                           wb_data};

    assign mem_bypass = {wb_data, held_q[WREG_IDX_LO +: 5], held_q[WREG_EN_BIT] & right_valid};

    // alu_op, Imm, rs2/src1 are carried in the latch but not needed after accept.
    logic unused_held;
    assign unused_held = ^{held_q[212:199], held_q[197:166], held_q[95:32]};

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// tb_mem_stage: directed stimulus for mem_stage with a spec-level model and a per-cycle compare process.
// A memory responder with programmable gnt/rvalid stalls answers requests; directed checks pin latencies.
// Summary line reports comparisons made and failures.
module tb_mem_stage;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    logic         clk;
    logic         reset;
    logic [212:0] ex_ctrl_bus;
    logic         left_valid;
    logic         left_ready;
    logic         right_valid;
    logic         right_ready;
    logic [102:0] mem_ctrl_bus;
    logic [37:0]  mem_bypass;
    logic         load_pending;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_wstrb;
    logic [31:0]  dmem_wdata;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [31:0]  dmem_rdata;

    // Memory responder (auto) or hand-driven response (manual).
    logic         mem_manual;
    logic         auto_gnt, auto_rvalid, man_gnt, man_rvalid;
    logic [31:0]  auto_rdata, man_rdata, mem_rdata;
    int           gnt_wait, rv_wait;

    assign dmem_gnt    = mem_manual ? man_gnt    : auto_gnt;
    assign dmem_rvalid = mem_manual ? man_rvalid : auto_rvalid;
    assign dmem_rdata  = mem_manual ? man_rdata  : auto_rdata;

    int   n_checks;
    int   n_fail;
    logic chk_en;

    logic [102:0] out_q[$];
    req_t         req_q[$];

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ex_ctrl_bus  (ex_ctrl_bus),
        .left_valid   (left_valid),
        .left_ready   (left_ready),
        .right_valid  (right_valid),
        .right_ready  (right_ready),
        .mem_ctrl_bus (mem_ctrl_bus),
        .mem_bypass   (mem_bypass),
        .load_pending (load_pending),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [212:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic wen, input logic [31:0] res, input logic [31:0] rs2,
                                        input logic [31:0] pc, input logic iv);
        logic [212:0] b;
        b           = '0;
        b[212:199]  = 14'h0155;
        b[198]      = iv;
        b[197:166]  = 32'h0000_0abc;
        b[165:134]  = pc;
        b[133:102]  = {17'h0, f3, rd, opc};
        b[101:97]   = rd;
        b[96]       = wen;
        b[95:64]    = rs2;
        b[63:32]    = 32'h1111_2222;
        b[31:0]     = res;
        return b;
    endfunction

    // What write-back must see for an instruction, given the word memory returns.
    function automatic logic [102:0] exp_out(input logic [212:0] b, input logic [31:0] rdata);
        logic [31:0] inst, res, v;
        int off;
        inst = b[133:102];
        res  = b[31:0];
        off  = int'(res % 4);
        v    = res;
        if (inst[6:0] == OP_LD) begin
            v = rdata >> (8 * off);
            case (inst[14:12])
                3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
                3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
                3'd4: v = v % 256;
                3'd5: v = v % 65536;
                default: ;
            endcase
        end
        return {b[198], b[165:134], inst, b[101:97], b[96], v};
    endfunction

    // What the request port must carry: lane i of a store is enabled when it lies inside the access.
    function automatic req_t exp_req(input logic [212:0] b);
        req_t r;
        logic [31:0] inst, res, rs2;
        int off, size;
        inst    = b[133:102];
        res     = b[31:0];
        rs2     = b[95:64];
        off     = int'(res % 4);
        size    = (inst[14:12] == 3'd0) ? 1 : (inst[14:12] == 3'd1) ? 2 : 4;
        r.we    = (inst[6:0] == OP_ST);
        r.addr  = res - 32'(off);
        r.strb  = 4'h0;
        r.wdata = 32'h0;
        if (r.we) begin
            for (int i = 0; i < 4; i++) begin
                r.strb[i]         = (size == 4) || (i >= off && i < off + size);
                r.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [212:0] b);
        logic [6:0] opc;
        opc = b[108:102];
        out_q.push_back(exp_out(b, mem_rdata));
        if (opc == OP_LD || (opc == OP_ST && b[198])) req_q.push_back(exp_req(b));
    endtask

    // Offer b until accepted; returns at the negedge after the accepting edge.
    task automatic send(input logic [212:0] b);
        int n;
        @(negedge clk);
        ex_ctrl_bus = b;
        left_valid  = 1'b1;
        #1;
        n = 0;
        while (!left_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!left_ready) check("send_timeout_left_ready", left_ready, 1'b1);
        push_exp(b);
        @(negedge clk);
        left_valid = 1'b0;
    endtask

    // Count cycles until right_valid; a timeout shows up as a wrong latency.
    task automatic wait_rv(output int n);
        n = 0;
        while (!right_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int gw, input int rw,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wb);
        int n;
        mem_rdata = rdata; gnt_wait = gw; rv_wait = rw;
        send(mk(OP_LD, f3, 5'd7, 1'b1, addr, 32'h0, 32'h0000_0200, 1'b1));
        #1;
        check({nm, "_req"}, dmem_req, 1'b1);
        check({nm, "_addr"}, dmem_addr, exp_addr);
        check({nm, "_we"}, dmem_we, 1'b0);
        check({nm, "_pending"}, load_pending, 1'b1);
        wait_rv(n);
        check({nm, "_latency"}, n, 2 + gw + rw - 1);
        check({nm, "_wb"}, mem_ctrl_bus[31:0], exp_wb);
        check({nm, "_pending_done"}, load_pending, 1'b0);
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input int gw, input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int n;
        mem_rdata = 32'hFFFF_FFFF; gnt_wait = gw; rv_wait = 1;
        send(mk(OP_ST, f3, 5'd0, 1'b0, addr, rs2, 32'h0000_0300, 1'b1));
        #1;
        for (int k = 0; k <= gw; k++) begin
            check({nm, "_req"}, dmem_req, 1'b1);
            check({nm, "_we"}, dmem_we, 1'b1);
            check({nm, "_addr"}, dmem_addr, exp_addr);
            check({nm, "_strb"}, dmem_wstrb, exp_strb);
            check({nm, "_wdata"}, dmem_wdata, exp_wdata);
            check({nm, "_gnt"}, dmem_gnt, (k == gw));
            if (k < gw) begin @(negedge clk); #1; end
        end
        wait_rv(n);
        check({nm, "_latency_after_gnt"}, n, 2);
        check({nm, "_wb"}, mem_ctrl_bus[31:0], addr);
    endtask

    // Memory responder: gnt after gnt_wait stalled cycles, rvalid rv_wait cycles after gnt.
    initial begin
        int ph, cnt;
        auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = 32'h0;
        ph = 0; cnt = 0;
        forever begin
            @(negedge clk);
            auto_gnt    = 1'b0;
            auto_rvalid = 1'b0;
            if (!reset || mem_manual) begin
                ph = 0; cnt = 0;
            end else begin
                if (ph == 0 && dmem_req) begin ph = 1; cnt = 0; end
                if (ph == 1) begin
                    if (cnt >= gnt_wait) begin auto_gnt = 1'b1; ph = 2; cnt = 0; end
                    else cnt++;
                end else if (ph == 2) begin
                    cnt++;
                    if (cnt >= rv_wait) begin auto_rvalid = 1'b1; auto_rdata = mem_rdata; ph = 0; end
                end
            end
        end
    end

    // Compare process: every cycle, outputs against the model queues.
    initial begin
        logic [102:0] e;
        req_t r;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                if (right_valid) begin
                    if (out_q.size() == 0) begin
                        check("unexpected_right_valid", right_valid, 1'b0);
                    end else begin
                        e = out_q[0];
                        check("cmp_ctrl_bus", mem_ctrl_bus, e);
                        check("cmp_bypass", mem_bypass, {e[31:0], e[37:33], e[32]});
                        if (right_ready) void'(out_q.pop_front());
                    end
                end else begin
                    check("cmp_bypass_en_idle", mem_bypass[0], 1'b0);
                end
                if (dmem_req) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_dmem_req", dmem_req, 1'b0);
                    end else begin
                        r = req_q[0];
                        check("cmp_req_we", dmem_we, r.we);
                        check("cmp_req_addr", dmem_addr, r.addr);
                        if (r.we) begin
                            check("cmp_req_strb", dmem_wstrb, r.strb);
                            check("cmp_req_wdata", dmem_wdata, r.wdata);
                        end
                        check("cmp_load_pending", load_pending, !r.we);
                        if (dmem_gnt) void'(req_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [212:0] b1, b2;
        int n;
        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        reset = 1'b0; left_valid = 1'b0; ex_ctrl_bus = '0; right_ready = 1'b0;
        mem_manual = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
        mem_rdata = 32'h0; gnt_wait = 0; rv_wait = 1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_left_ready", left_ready, 1'b1);
        check("rst_right_valid", right_valid, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_load_pending", load_pending, 1'b0);
        check("rst_bypass", mem_bypass, 38'h0);
        check("rst_ctrl_bus", mem_ctrl_bus, 103'h0);
        @(negedge clk);
        reset = 1'b1; chk_en = 1'b1; right_ready = 1'b1;

        // Pass-through addi.
        send(mk(OP_IMM, 3'd0, 5'd5, 1'b1, 32'h0000_0055, 32'h0, 32'h0000_0100, 1'b1));
        #1;
        wait_rv(n);
        check("pt_latency", n, 0);
        check("pt_wb", mem_ctrl_bus[31:0], 32'h55);
        check("pt_bypass", mem_bypass, {32'h55, 5'd5, 1'b1});
        check("pt_no_req", dmem_req, 1'b0);
        @(negedge clk); #1;
        check("pt_one_cycle", right_valid, 1'b0);

        // Loads: funct3, offset, stalls.
        do_load("lb",  3'd0, 32'h0000_1003, 32'h80AA_BBCC, 0, 1, 32'h0000_1000, 32'hFFFF_FF80);
        do_load("lbu", 3'd4, 32'h0000_1003, 32'h80AA_BBCC, 0, 1, 32'h0000_1000, 32'h0000_0080);
        do_load("lh",  3'd1, 32'h0000_1006, 32'h80AA_BBCC, 2, 3, 32'h0000_1004, 32'hFFFF_80AA);
        do_load("lhu", 3'd5, 32'h0000_1004, 32'h80AA_BBCC, 0, 1, 32'h0000_1004, 32'h0000_BBCC);
        do_load("lw",  3'd2, 32'h0000_1008, 32'h80AA_BBCC, 1, 1, 32'h0000_1008, 32'h80AA_BBCC);
        do_load("lbp", 3'd0, 32'h0000_100D, 32'h0000_7F00, 0, 2, 32'h0000_100C, 32'h0000_007F);
        do_load("lf3", 3'd3, 32'h0000_1010, 32'h1234_5678, 0, 1, 32'h0000_1010, 32'h1234_5678);

        // Stores: strobes, replication, dropped lanes.
        do_store("sh",   3'd1, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
        do_store("sb1",  3'd0, 32'h0000_2001, 32'h0000_00EF, 0, 32'h0000_2000, 4'b0010, 32'hEFEF_EFEF);
        do_store("sw",   3'd2, 32'h0000_2004, 32'hDEAD_BEEF, 1, 32'h0000_2004, 4'b1111, 32'hDEAD_BEEF);
        do_store("sh3",  3'd1, 32'h0000_2003, 32'h1234_ABCD, 0, 32'h0000_2000, 4'b1000, 32'hABCD_ABCD);
        do_store("sb3",  3'd0, 32'h0000_2003, 32'h0000_445A, 0, 32'h0000_2000, 4'b1000, 32'h5A5A_5A5A);

        // Store opcode in a bubble slot passes through.
        send(mk(OP_ST, 3'd2, 5'd0, 1'b0, 32'h0000_0077, 32'h99, 32'h0000_0400, 1'b0));
        #1;
        wait_rv(n);
        check("bubble_latency", n, 0);
        check("bubble_no_req", dmem_req, 1'b0);
        check("bubble_wb", mem_ctrl_bus[31:0], 32'h77);
        check("bubble_inst_valid", mem_ctrl_bus[102], 1'b0);

        // Backpressure in DONE, then hand-off and accept in the same cycle.
        b1 = mk(OP_IMM, 3'd0, 5'd9,  1'b1, 32'hA5A5_0001, 32'h0, 32'h0000_0500, 1'b1);
        b2 = mk(OP_IMM, 3'd0, 5'd10, 1'b1, 32'h0000_BEEF, 32'h0, 32'h0000_0504, 1'b1);
        @(negedge clk);
        right_ready = 1'b0;
        send(b1);
        ex_ctrl_bus = b2;
        left_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_right_valid", right_valid, 1'b1);
            check("bp_left_ready", left_ready, 1'b0);
            check("bp_wb", mem_ctrl_bus[31:0], 32'hA5A5_0001);
            check("bp_bypass", mem_bypass, {32'hA5A5_0001, 5'd9, 1'b1});
            @(negedge clk);
        end
        right_ready = 1'b1;
        #1;
        check("bp_release_left_ready", left_ready, 1'b1);
        push_exp(b2);
        @(negedge clk);
        left_valid = 1'b0;
        #1;
        check("bp_next_valid", right_valid, 1'b1);
        check("bp_next_wb", mem_ctrl_bus[31:0], 32'h0000_BEEF);
        check("bp_next_bypass", mem_bypass, {32'h0000_BEEF, 5'd10, 1'b1});

        // Reset while waiting for the response.
        mem_manual = 1'b1; man_gnt = 1'b0; man_rvalid = 1'b0; mem_rdata = 32'h0;
        send(mk(OP_LD, 3'd2, 5'd4, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0600, 1'b1));
        man_gnt = 1'b1;
        #1;
        check("rm_req", dmem_req, 1'b1);
        @(negedge clk);
        man_gnt = 1'b0;
        #1;
        check("rm_wait_req", dmem_req, 1'b0);
        check("rm_wait_pending", load_pending, 1'b1);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rm_rst_req", dmem_req, 1'b0);
        check("rm_rst_right_valid", right_valid, 1'b0);
        check("rm_rst_pending", load_pending, 1'b0);
        check("rm_rst_left_ready", left_ready, 1'b1);
        out_q.delete();
        req_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        check("rm_rvalid_ignored", right_valid, 1'b0);
        check("rm_idle_left_ready", left_ready, 1'b1);
        check("rm_idle_pending", load_pending, 1'b0);
        @(negedge clk); #1;
        check("rm_still_idle", right_valid, 1'b0);
        mem_manual = 1'b0;
        chk_en = 1'b1;

        // Recovery after reset.
        send(mk(OP_IMM, 3'd0, 5'd3, 1'b1, 32'h0000_0033, 32'h0, 32'h0000_0700, 1'b1));
        #1;
        wait_rv(n);
        check("post_latency", n, 0);
        check("post_wb", mem_ctrl_bus[31:0], 32'h33);

        repeat (4) @(negedge clk);
        #3;
        check("drain_out_q", out_q.size(), 0);
        check("drain_req_q", req_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
